// File: rtl/ram_word_bridge_pkg.sv
// rtl/ram_word_bridge_pkg.sv - shared widths, FSM states and byte-lane helper for ram_word_bridge
package ram_word_bridge_pkg;

  localparam int RAM_AW  = 15;
  localparam int WORD_AW = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B0   = 2'd1,
    ST_B1   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Even byte lives in the high half of the word when big-endian.
  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic odd,
                                           input logic big_endian);
    return (odd ^ big_endian) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/ram_word_bridge_if.sv
// rtl/ram_word_bridge_if.sv - CPU word port, video byte port and RAM pins of ram_word_bridge
interface ram_word_bridge_if;
  import ram_word_bridge_pkg::*;

  logic               req;
  logic               we;
  logic [WORD_AW-1:0] addr;
  logic [1:0]         be;
  logic [15:0]        wdata;
  logic [15:0]        rdata;
  logic               ack;
  logic               busy;

  logic               vid_req;
  logic [RAM_AW-1:0]  vid_addr;
  logic [7:0]         vid_data;
  logic               vid_ack;

  logic               ram_en;
  logic               ram_wr;
  logic [RAM_AW-1:0]  ram_addr;
  logic [7:0]         ram_din;
  logic [7:0]         ram_dout;

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack, busy,
    input  vid_req, vid_addr,
    output vid_data, vid_ack,
    output ram_en, ram_wr, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack, busy,
    output vid_req, vid_addr,
    input  vid_data, vid_ack,
    input  ram_en, ram_wr, ram_addr, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/ram_word_bridge.sv
// rtl/ram_word_bridge.sv - splits 16-bit CPU word accesses into two byte RAM cycles,
// with a video byte-read port that always wins the RAM pins.
module ram_word_bridge
  import ram_word_bridge_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_word_bridge_if.slave   bus
);

  state_t             state;
  state_t             state_next;
  logic               we_q;
  logic [WORD_AW-1:0] addr_q;
  logic [1:0]         be_q;
  logic [15:0]        wdata_q;
  logic [15:0]        rdata_q;

  logic               lane;
  logic               cpu_access;
  logic               ram_en;
  logic               ram_wr;
  logic [RAM_AW-1:0]  ram_addr;
  logic [7:0]         ram_din;

  assign lane       = (state == ST_B1);
  assign cpu_access = ((state == ST_B0) || (state == ST_B1)) && !bus.vid_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 2'b00;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state <= state_next;
      if ((state == ST_IDLE) && bus.req) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        be_q    <= bus.be;
        wdata_q <= bus.wdata;
      end
      if (cpu_access && !we_q) begin
        if (lane ^ BIG_ENDIAN) rdata_q[15:8] <= bus.ram_dout;
        else                   rdata_q[7:0]  <= bus.ram_dout;
      end
    end
  end

  // Byte states only advance on cycles the RAM actually served the CPU.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.req)      state_next = ST_B0;
      ST_B0:   if (!bus.vid_req) state_next = ST_B1;
      ST_B1:   if (!bus.vid_req) state_next = ST_DONE;
      ST_DONE:                   state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_en   = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = {addr_q, lane};
    ram_din  = lane_byte(wdata_q, lane, BIG_ENDIAN);
    if (bus.vid_req) begin
      ram_en   = 1'b1;
      ram_addr = bus.vid_addr;
    end else if (cpu_access) begin
      ram_en = 1'b1;
      ram_wr = we_q & be_q[lane];
    end
  end

  assign bus.ram_en   = ram_en;
  assign bus.ram_wr   = ram_wr;
  assign bus.ram_addr = ram_addr;
  assign bus.ram_din  = ram_din;

  assign bus.rdata    = rdata_q;
  assign bus.ack      = (state == ST_DONE);
  assign bus.busy     = (state != ST_IDLE);
  assign bus.vid_data = bus.ram_dout;
  assign bus.vid_ack  = bus.vid_req;

endmodule

// File: tb/tb_ram_word_bridge.sv
// tb/tb_ram_word_bridge.sv - randomized self-checking bench for ram_word_bridge (big- and
// little-endian instances sharing one byte image; LE write data is byte-swapped to match).
module tb_ram_word_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [13:0] addr = '0;
  logic [1:0]  be = '0;
  logic [15:0] wdata = '0;
  logic        vid_req = 1'b0;
  logic [14:0] vid_addr = '0;

  logic [7:0]  mem_be  [0:32767];
  logic [7:0]  mem_le  [0:32767];
  logic [7:0]  ref_mem [0:32767];

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;

  logic        exp_busy = 1'b0;
  logic        exp_ack = 1'b0;
  logic        exp_access = 1'b0;
  logic        exp_wr = 1'b0;
  logic [14:0] exp_ram_addr = '0;
  logic [7:0]  exp_din = '0;
  logic [15:0] exp_rd_be = '0;
  logic [15:0] exp_rd_le = '0;

  always #5 clk = ~clk;

  ram_word_bridge_if bus_be ();
  ram_word_bridge_if bus_le ();

  ram_word_bridge #(.BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .rst_n(rst_n), .bus(bus_be.slave));
  ram_word_bridge #(.BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .rst_n(rst_n), .bus(bus_le.slave));

  assign bus_be.req      = req;
  assign bus_be.we       = we;
  assign bus_be.addr     = addr;
  assign bus_be.be       = be;
  assign bus_be.wdata    = wdata;
  assign bus_be.vid_req  = vid_req;
  assign bus_be.vid_addr = vid_addr;
  assign bus_le.req      = req;
  assign bus_le.we       = we;
  assign bus_le.addr     = addr;
  assign bus_le.be       = be;
  assign bus_le.wdata    = {wdata[7:0], wdata[15:8]};
  assign bus_le.vid_req  = vid_req;
  assign bus_le.vid_addr = vid_addr;

  assign bus_be.ram_dout = mem_be[bus_be.ram_addr];
  assign bus_le.ram_dout = mem_le[bus_le.ram_addr];

  always @(posedge clk) begin
    if (bus_be.ram_en && bus_be.ram_wr) mem_be[bus_be.ram_addr] <= bus_be.ram_din;
    if (bus_le.ram_en && bus_le.ram_wr) mem_le[bus_le.ram_addr] <= bus_le.ram_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_pins(input string tag, input logic ack_a, input logic busy_a,
                            input logic [15:0] rd_a, input logic en_a, input logic wr_a,
                            input logic [14:0] ra_a, input logic [7:0] din_a,
                            input logic [7:0] vd_a, input logic vack_a,
                            input logic [7:0] vd_e, input logic [15:0] rd_e);
    chk({tag, ".vid_ack"}, 32'(vack_a), 32'(vid_req));
    if (vid_req) begin
      chk({tag, ".vid_en"},   32'(en_a), 32'd1);
      chk({tag, ".vid_wr"},   32'(wr_a), 32'd0);
      chk({tag, ".vid_addr"}, 32'(ra_a), 32'(vid_addr));
      chk({tag, ".vid_data"}, 32'(vd_a), 32'(vd_e));
    end else if (exp_access) begin
      chk({tag, ".cpu_en"},   32'(en_a), 32'd1);
      chk({tag, ".cpu_addr"}, 32'(ra_a), 32'(exp_ram_addr));
      chk({tag, ".cpu_wr"},   32'(wr_a), 32'(exp_wr));
      if (exp_wr) chk({tag, ".cpu_din"}, 32'(din_a), 32'(exp_din));
    end else begin
      chk({tag, ".idle_en"}, 32'(en_a), 32'd0);
    end
    chk({tag, ".busy"}, 32'(busy_a), 32'(exp_busy));
    chk({tag, ".ack"},  32'(ack_a),  32'(exp_ack));
    if (!exp_busy || exp_ack) chk({tag, ".rdata"}, 32'(rd_a), 32'(rd_e));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_pins("be", bus_be.ack, bus_be.busy, bus_be.rdata, bus_be.ram_en, bus_be.ram_wr,
                 bus_be.ram_addr, bus_be.ram_din, bus_be.vid_data, bus_be.vid_ack,
                 mem_be[vid_addr], exp_rd_be);
      check_pins("le", bus_le.ack, bus_le.busy, bus_le.rdata, bus_le.ram_en, bus_le.ram_wr,
                 bus_le.ram_addr, bus_le.ram_din, bus_le.vid_data, bus_le.vid_ack,
                 mem_le[vid_addr], exp_rd_le);
    end
  end

  // Transaction model: a word needs two cycles without video after acceptance, then one
  // ack cycle. Returns in the ack cycle with the reference image and expected rdata updated.
  task automatic op(input logic w, input logic [13:0] a, input logic [1:0] b,
                    input logic [15:0] d, input int nvid, input bit rvid, output int lat);
    int k;
    int good;
    logic [7:0] ev;
    logic [7:0] od;
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    vid_req  = rvid ? 1'($urandom_range(0, 3) == 0) : 1'b0;
    vid_addr = 15'($urandom);
    exp_busy = 1'b0; exp_ack = 1'b0; exp_access = 1'b0;
    k = 0; good = 0; lat = 0;
    while (lat == 0) begin
      @(posedge clk); #1;
      k++;
      we = 1'($urandom); addr = 14'($urandom); be = 2'($urandom); wdata = 16'($urandom);
      vid_addr = 15'($urandom);
      exp_busy = 1'b1;
      if (good == 2) begin
        req = 1'b0;
        vid_req = rvid ? 1'($urandom_range(0, 3) == 0) : 1'b0;
        exp_ack = 1'b1; exp_access = 1'b0;
        if (w) begin
          if (b[0]) ref_mem[{a, 1'b0}] = d[15:8];
          if (b[1]) ref_mem[{a, 1'b1}] = d[7:0];
        end else begin
          ev = ref_mem[{a, 1'b0}];
          od = ref_mem[{a, 1'b1}];
          exp_rd_be = {ev, od};
          exp_rd_le = {od, ev};
        end
        lat = k;
      end else begin
        vid_req = (k <= nvid) ? 1'b1 : (rvid ? 1'($urandom_range(0, 3) == 0) : 1'b0);
        exp_ack = 1'b0;
        exp_access = !vid_req;
        if (!vid_req) begin
          exp_ram_addr = {a, good[0]};
          exp_wr  = w & b[good];
          exp_din = (good == 0) ? d[15:8] : d[7:0];
          good++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req = 1'b0;
      vid_req  = 1'($urandom_range(0, 2) == 0);
      vid_addr = 15'($urandom);
      exp_busy = 1'b0; exp_ack = 1'b0; exp_access = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int mism_be;
    int mism_le;
    for (int i = 0; i < 32768; i++) begin
      mem_be[i]  = 8'(i) ^ 8'h5C;
      mem_le[i]  = 8'(i) ^ 8'h5C;
      ref_mem[i] = 8'(i) ^ 8'h5C;
    end

    #2;
    chk("rst_busy", 32'(bus_be.busy), 32'd0);
    chk("rst_ack", 32'(bus_be.ack), 32'd0);
    chk("rst_rdata", 32'(bus_be.rdata), 32'd0);
    chk("rst_ram_en", 32'(bus_be.ram_en), 32'd0);
    vid_req = 1'b1; vid_addr = 15'h0123;
    #1;
    chk("rst_vid_en", 32'(bus_be.ram_en), 32'd1);
    chk("rst_vid_addr", 32'(bus_le.ram_addr), 32'h0123);
    chk("rst_vid_data", 32'(bus_be.vid_data), 32'h7F);
    chk("rst_vid_ack", 32'(bus_le.vid_ack), 32'd1);
    vid_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    op(1'b1, 14'h0010, 2'b11, 16'hA55A, 0, 1'b0, lat);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_even", 32'(mem_be[15'h0020]), 32'hA5);
    chk("wr_odd", 32'(mem_be[15'h0021]), 32'h5A);
    chk("wr_le_even", 32'(mem_le[15'h0020]), 32'hA5);

    op(1'b0, 14'h0010, 2'b00, 16'h0000, 0, 1'b0, lat);
    chk("rd_be", 32'(bus_be.rdata), 32'hA55A);
    chk("rd_le", 32'(bus_le.rdata), 32'h5AA5);
    chk("rd_ack", 32'(bus_be.ack), 32'd1);

    op(1'b1, 14'h0010, 2'b10, 16'h1234, 0, 1'b0, lat);
    chk("be10_even", 32'(mem_be[15'h0020]), 32'hA5);
    chk("be10_odd", 32'(mem_be[15'h0021]), 32'h34);
    chk("be10_rdata_kept", 32'(bus_be.rdata), 32'hA55A);

    op(1'b0, 14'h0010, 2'b00, 16'h0000, 5, 1'b0, lat);
    chk("vid_stall_latency", 32'(lat), 32'd8);
    chk("vid_stall_rd_be", 32'(bus_be.rdata), 32'hA534);
    chk("vid_stall_rd_le", 32'(bus_le.rdata), 32'h34A5);

    op(1'b1, 14'h3FFF, 2'b11, 16'hBEEF, 0, 1'b0, lat);
    chk("wrap_even", 32'(mem_be[15'h7FFE]), 32'hBE);
    chk("wrap_odd", 32'(mem_be[15'h7FFF]), 32'hEF);
    chk("wrap_ram0", 32'(mem_be[15'h0000]), 32'h5C);
    chk("wrap_ram1", 32'(mem_be[15'h0001]), 32'h5D);

    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 14'h0040; be = 2'b11; wdata = 16'hC3D4; vid_req = 1'b0;
    exp_busy = 1'b0; exp_ack = 1'b0; exp_access = 1'b0;
    @(posedge clk); #1;
    exp_busy = 1'b1; exp_access = 1'b1; exp_ram_addr = 15'h0080; exp_wr = 1'b1; exp_din = 8'hC3;
    @(posedge clk); #1;
    rst_n = 1'b0; req = 1'b0;
    exp_busy = 1'b0; exp_access = 1'b0; exp_rd_be = 16'h0000; exp_rd_le = 16'h0000;
    ref_mem[15'h0080] = 8'hC3;
    #1;
    chk("midrst_busy", 32'(bus_be.busy), 32'd0);
    chk("midrst_ack", 32'(bus_le.ack), 32'd0);
    chk("midrst_rdata_be", 32'(bus_be.rdata), 32'd0);
    chk("midrst_rdata_le", 32'(bus_le.rdata), 32'd0);
    chk("midrst_even", 32'(mem_be[15'h0080]), 32'hC3);
    chk("midrst_odd", 32'(mem_be[15'h0081]), 32'hDD);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int n = 0; n < 200; n++) begin
      logic [13:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? 14'(14'h3FFF - 14'($urandom_range(0, 3)))
                                       : 14'($urandom_range(0, 31));
      op(1'($urandom), ra, 2'($urandom), 16'($urandom), 0, 1'b1, lat);
      idle($urandom_range(0, 2));
    end
    idle(1);
    chk_en = 1'b0;

    mism_be = 0;
    mism_le = 0;
    for (int i = 0; i < 32768; i++) begin
      if (mem_be[i] !== ref_mem[i]) mism_be++;
      if (mem_le[i] !== ref_mem[i]) mism_le++;
    end
    chk("mem_final_be", 32'(mism_be), 32'd0);
    chk("mem_final_le", 32'(mism_le), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
